// File: rtl/usbdev_pkg.sv
// Shared USB device definitions: remote-wake FSM encoding and default timing,
// also used by the register block to decode the wake status field.
package usbdev_pkg;

    typedef enum logic [1:0] {
        WakeIdle     = 2'd0,
        WakeWaitIdle = 2'd1,
        WakeDriveK   = 2'd2,
        WakeWaitHost = 2'd3
    } usbdev_wake_state_e;

    // Times in microsecond ticks; suspend entry already provides 3 ms of idle.
    localparam int UsbWakeIdleUs     = 2000;
    localparam int UsbWakeDriveKUs   = 2000;
    localparam int UsbWakeHostRespUs = 20000;

endpackage

// File: rtl/usbdev_remote_wake.sv
// Device-initiated remote-wakeup sequencer: waits for bus idle, drives resume K
// for a fixed time, then waits for the host to take over resume signaling.
module usbdev_remote_wake
    import usbdev_pkg::*;
#(
    parameter int IdleUs     = UsbWakeIdleUs,
    parameter int DriveKUs   = UsbWakeDriveKUs,
    parameter int HostRespUs = UsbWakeHostRespUs,
    parameter int CntW       = 15
) (
    input  logic       clk_48mhz_i,
    input  logic       rst_ni,
    input  logic       us_tick_i,
    input  logic       wake_req_i,
    input  logic       remote_wake_en_i,
    input  logic       link_suspend_i,
    input  logic       link_disconnect_i,
    input  logic       link_active_i,
    input  logic       link_resume_i,
    input  logic       rx_idle_det_i,
    output logic       drive_k_o,
    output logic       wake_busy_o,
    output logic       wake_done_o,
    output logic       wake_err_o,
    output logic [1:0] wake_state_o
);

    localparam logic [CntW-1:0] IdleLast  = CntW'(IdleUs - 1);
    localparam logic [CntW-1:0] DriveLast = CntW'(DriveKUs - 1);
    localparam logic [CntW-1:0] HostLast  = CntW'(HostRespUs - 1);
    localparam logic [CntW-1:0] CntMax    = '1;

    usbdev_wake_state_e state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WakeIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Disconnect outranks everything once a sequence is running.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            WakeIdle: begin
                if (wake_req_i) begin
                    if (remote_wake_en_i && link_suspend_i && !link_disconnect_i) begin
                        state_d = WakeWaitIdle;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WakeWaitIdle: begin
                if (link_disconnect_i || !link_suspend_i || !rx_idle_det_i) begin
                    state_d = WakeIdle;
                    err_d   = 1'b1;
                end else if (us_tick_i && cnt_q == IdleLast) begin
                    state_d = WakeDriveK;
                end
            end
            WakeDriveK: begin
                // Our own K perturbs suspend/idle detection, so only disconnect aborts here.
                if (link_disconnect_i) begin
                    state_d = WakeIdle;
                    err_d   = 1'b1;
                end else if (us_tick_i && cnt_q == DriveLast) begin
                    state_d = WakeWaitHost;
                end
            end
            WakeWaitHost: begin
                if (link_disconnect_i) begin
                    state_d = WakeIdle;
                    err_d   = 1'b1;
                end else if (link_resume_i || link_active_i) begin
                    state_d = WakeIdle;
                    done_d  = 1'b1;
                end else if (us_tick_i && cnt_q == HostLast) begin
                    state_d = WakeIdle;
                    err_d   = 1'b1;
                end
            end
            default: state_d = WakeIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (us_tick_i && cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        drive_k_o    = (state_q == WakeDriveK);
        wake_busy_o  = (state_q != WakeIdle);
        wake_state_o = state_q;
        wake_done_o  = done_q;
        wake_err_o   = err_q;
    end

    a_state_known: assert property (@(posedge clk_48mhz_i) disable iff (!rst_ni)
        !$isunknown(state_q));
    a_drive_k_only_in_drivek: assert property (@(posedge clk_48mhz_i) disable iff (!rst_ni)
        drive_k_o |-> (state_q == WakeDriveK));

endmodule

// File: tb/tb_usbdev_remote_wake.sv
// Randomized and directed bench for usbdev_remote_wake against a phase/tick-count model.
module tb_usbdev_remote_wake;

    localparam int TIdle  = 40;
    localparam int TDrive = 1000;
    localparam int THost  = 200;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic       us_tick = 1'b0;
    logic       wake_req = 1'b0;
    logic       en = 1'b0;
    logic       susp = 1'b0;
    logic       disc = 1'b0;
    logic       active = 1'b0;
    logic       resume = 1'b0;
    logic       rx_idle = 1'b0;
    logic       drive_k_o, wake_busy_o, wake_done_o, wake_err_o;
    logic [1:0] wake_state_o;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  rnd_tick = 1'b0;

    // Model: phase number and ticks spent in it; a phase ends on its lim()-th tick.
    int  ph = 0;
    int  t = 0;
    bit  e_done = 1'b0;
    bit  e_err = 1'b0;

    always #10 clk = ~clk;

    usbdev_remote_wake #(
        .IdleUs(TIdle), .DriveKUs(TDrive), .HostRespUs(THost), .CntW(15)
    ) dut (
        .clk_48mhz_i      (clk),
        .rst_ni           (rst_ni),
        .us_tick_i        (us_tick),
        .wake_req_i       (wake_req),
        .remote_wake_en_i (en),
        .link_suspend_i   (susp),
        .link_disconnect_i(disc),
        .link_active_i    (active),
        .link_resume_i    (resume),
        .rx_idle_det_i    (rx_idle),
        .drive_k_o        (drive_k_o),
        .wake_busy_o      (wake_busy_o),
        .wake_done_o      (wake_done_o),
        .wake_err_o       (wake_err_o),
        .wake_state_o     (wake_state_o)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lim(input int p);
        if (p == 1) return TIdle;
        if (p == 2) return TDrive;
        return THost;
    endfunction

    function automatic void model_reset();
        ph = 0; t = 0; e_done = 1'b0; e_err = 1'b0;
    endfunction

    function automatic void model_edge();
        int nxt;
        nxt = ph;
        e_done = 1'b0;
        e_err = 1'b0;
        if (ph == 0) begin
            if (wake_req) begin
                if (en && susp && !disc) nxt = 1;
                else e_err = 1'b1;
            end
        end else if (disc) begin
            nxt = 0; e_err = 1'b1;
        end else if (ph == 3 && (resume || active)) begin
            nxt = 0; e_done = 1'b1;
        end else if (ph == 1 && !(susp && rx_idle)) begin
            nxt = 0; e_err = 1'b1;
        end else if (us_tick && t + 1 >= lim(ph)) begin
            nxt = (ph + 1) % 4;
            e_err = (ph == 3);
        end
        if (nxt != ph) t = 0;
        else if (us_tick) t++;
        ph = nxt;
    endfunction

    task automatic cycle();
        us_tick = rnd_tick ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_eq("outs", {26'd0, wake_state_o, drive_k_o, wake_busy_o, wake_done_o, wake_err_o},
               {26'd0, 2'(ph), ph == 2, ph != 0, e_done, e_err});
    endtask

    task automatic wait_drive(input logic lvl, output int n);
        n = 0;
        while (drive_k_o !== lvl && n < 5000) begin
            cycle();
            n++;
        end
    endtask

    task automatic request();
        wake_req = 1'b1;
        cycle();
        wake_req = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #3 rst_ni = 1'b0;
        #1;
        chk_eq(tag, {27'd0, wake_state_o, drive_k_o, wake_busy_o, wake_done_o, wake_err_o}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        int n;
        #5 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("reset", {27'd0, wake_state_o, drive_k_o, wake_busy_o, wake_done_o, wake_err_o}, 32'd0);
        rst_ni = 1'b1;
        susp = 1'b1; rx_idle = 1'b1; en = 1'b1;
        cycle();

        // Accepted wake completed by host resume
        request();
        wait_drive(1'b1, n);
        chk_eq("k_rise_ticks", n, TIdle);
        wait_drive(1'b0, n);
        chk_eq("k_width_ticks", n, TDrive);
        repeat (100) cycle();
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        chk_eq("done_pulse", wake_done_o, 1);
        chk_eq("done_state", wake_state_o, 0);
        cycle();
        chk_eq("done_once", wake_done_o, 0);

        // Rejected request: feature not granted
        en = 1'b0;
        request();
        chk_eq("reject_err", wake_err_o, 1);
        chk_eq("reject_busy", wake_busy_o, 0);
        cycle();
        chk_eq("reject_err_once", wake_err_o, 0);
        en = 1'b1;

        // Bus activity during WaitIdle
        request();
        repeat (20) cycle();
        rx_idle = 1'b0;
        cycle();
        rx_idle = 1'b1;
        chk_eq("hostfirst_err", wake_err_o, 1);
        chk_eq("hostfirst_state", wake_state_o, 0);
        chk_eq("hostfirst_k", drive_k_o, 0);

        // Host never responds
        request();
        wait_drive(1'b1, n);
        wait_drive(1'b0, n);
        n = 0;
        while (wake_err_o !== 1'b1 && n < 5000) begin
            cycle();
            n++;
        end
        chk_eq("timeout_ticks", n, THost);
        chk_eq("timeout_state", wake_state_o, 0);

        // Completion coinciding with the timeout tick
        request();
        wait_drive(1'b1, n);
        wait_drive(1'b0, n);
        repeat (THost - 1) cycle();
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        chk_eq("coincide_done", wake_done_o, 1);
        chk_eq("coincide_err", wake_err_o, 0);

        // Disconnect during DriveK, then a request while still disconnected
        request();
        wait_drive(1'b1, n);
        repeat (100) cycle();
        disc = 1'b1;
        cycle();
        chk_eq("disc_k", drive_k_o, 0);
        chk_eq("disc_err", wake_err_o, 1);
        cycle();
        chk_eq("disc_err_once", wake_err_o, 0);
        request();
        chk_eq("disc_reject_err", wake_err_o, 1);
        chk_eq("disc_reject_busy", wake_busy_o, 0);
        disc = 1'b0;
        cycle();

        // Asynchronous reset in WaitHost and in DriveK
        request();
        wait_drive(1'b1, n);
        wait_drive(1'b0, n);
        repeat (50) cycle();
        async_reset_check("rst_waithost");
        request();
        wait_drive(1'b1, n);
        repeat (10) cycle();
        async_reset_check("rst_drivek");
        cycle();

        // Randomized traffic
        rnd_tick = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            wake_req = ($urandom_range(0, 59) == 0);
            en       = ($urandom_range(0, 9) != 0);
            if (!disc) disc = ($urandom_range(0, 3999) == 0);
            else disc = ($urandom_range(0, 9) != 0);
            susp     = ($urandom_range(0, 1999) != 0);
            rx_idle  = ($urandom_range(0, 1499) != 0);
            resume   = ($urandom_range(0, 1499) == 0);
            active   = ($urandom_range(0, 4999) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usbdev_remote_wake.md
# usbdev_remote_wake

Device-initiated remote-wakeup sequencer for the USB device link layer. It accepts a software wake request while the link is suspended, enforces the minimum bus-idle interval, and drives resume (K) signaling for a fixed duration. It then waits for the host to take over resume signaling and reports completion or failure. It sits beside the link-state tracker, consuming its level outputs, and drives the PHY's K-override.

## Interface
Parameters:
- IdleUs, 2000: additional idle time required after the request, in us ticks, before driving K. Suspend entry already guarantees 3 ms of idle, so the total is at least 5 ms.
- DriveKUs, 2000: duration of device K drive, in us ticks. Legal range 1000-15000.
- HostRespUs, 20000: maximum wait for the host to complete resume after K is released, in us ticks.
- CntW, 15: timer width. Must satisfy 2^CntW > max(IdleUs, DriveKUs, HostRespUs).

Ports:
- clk_48mhz_i  in  1  48 MHz clock
- rst_ni  in  1  reset, asynchronous, active-low
- us_tick_i  in  1  one-cycle pulse every microsecond
- wake_req_i  in  1  software wake request (pulse)
- remote_wake_en_i  in  1  host-granted DEVICE_REMOTE_WAKEUP feature (level)
- link_suspend_i  in  1  link is in a suspended state (level)
- link_disconnect_i  in  1  link disconnected (level)
- link_active_i  in  1  link active (level)
- link_resume_i  in  1  link-state resume pulse
- rx_idle_det_i  in  1  bus idle (J) detected (level)
- drive_k_o  out  1  PHY override: drive K on the bus
- wake_busy_o  out  1  sequence in progress
- wake_done_o  out  1  pulse: host completed resume
- wake_err_o  out  1  pulse: request rejected, aborted or timed out
- wake_state_o  out  2  current FSM state, for the status register

## Operation
- FSM states: Idle=0, WaitIdle=1, DriveK=2, WaitHost=3. A single timer `cnt` is cleared on every state entry and increments on `us_tick_i`.
- Idle:
  - When `wake_req_i & remote_wake_en_i & link_suspend_i`, go to WaitIdle.
  - When `wake_req_i` arrives without both enable conditions, pulse `wake_err_o` and stay in Idle.
- WaitIdle:
  - If `!link_suspend_i` or `!rx_idle_det_i`, the host resumed first or bus activity occurred. Go to Idle and pulse `wake_err_o`.
  - Otherwise, when `us_tick_i` and `cnt == IdleUs-1`, go to DriveK.
- DriveK:
  - `drive_k_o = 1`.
  - `link_suspend_i` and `rx_idle_det_i` are ignored, since the device's own signaling perturbs them.
  - When `us_tick_i` and `cnt == DriveKUs-1`, go to WaitHost.
- WaitHost:
  - `drive_k_o = 0`.
  - On `link_resume_i | link_active_i`, go to Idle and pulse `wake_done_o`.
  - Otherwise, when `us_tick_i` and `cnt == HostRespUs-1`, go to Idle and pulse `wake_err_o`.
- `link_disconnect_i` has priority in every non-Idle state. It forces Idle and pulses `wake_err_o`. In Idle it suppresses request acceptance; a request arriving during disconnect gets the reject pulse.
- `wake_req_i` outside Idle is ignored, with no error pulse.
- `remote_wake_en_i` is sampled only at request acceptance. Deassertion mid-sequence has no effect.
- `wake_busy_o = (state != Idle)`. `wake_state_o` is the encoded state.
- The timer saturates at all-ones and never wraps. This is unreachable under the legal parameter range.

## Timing
- Reset values: state Idle, `cnt` 0. All outputs are 0: `drive_k_o`, `wake_busy_o`, `wake_done_o`, `wake_err_o`, and `wake_state_o` (2'd0).
- All outputs are decoded from registered state only, so there are no combinational paths from inputs.
- `wake_done_o` and `wake_err_o` are registered single-cycle pulses. Each asserts in the cycle after the triggering edge, coincident with `state == Idle`.
- `drive_k_o` rises exactly `IdleUs` us ticks after acceptance and stays high for exactly `DriveKUs` ticks. Edges are aligned to the cycle after the qualifying tick.
- Within WaitHost, if a completion event coincides with the timeout tick, completion wins.
- If reset asserts mid-DriveK, `drive_k_o` deasserts asynchronously.

## Structure
- `usbdev_pkg` holds the state enum `usbdev_wake_state_e` and the default constants `UsbWakeIdleUs`, `UsbWakeDriveKUs` and `UsbWakeHostRespUs`. These are shared with the register block for the status decode.
- No sub-module: one FSM plus one CntW-bit timer. An `ASSERT` checks that the state is legal and that `drive_k_o` is high only in DriveK.

## Test plan
- Accepted wake, then host resume: suspended, enable=1, request pulse. `drive_k_o` rises after 2000 ticks and stays high for 2000 ticks. Inject `link_resume_i` 500 ticks later: `wake_done_o` pulses once, state returns to 0.
- Rejected request: `remote_wake_en_i=0`, request pulse. `wake_err_o` pulses next cycle, `drive_k_o` never asserts, `wake_busy_o` stays 0.
- Host resumes first: in WaitIdle at tick 1000, drop `rx_idle_det_i`. Next cycle `wake_err_o` pulses, state returns to 0, and `drive_k_o` never asserts.
- Host timeout: no completion event. `wake_err_o` pulses exactly 20000 ticks after the falling edge of `drive_k_o`.
- Disconnect mid-DriveK: assert `link_disconnect_i` at tick 100 of DriveK. `drive_k_o` falls next cycle, `wake_err_o` pulses once. A second request while still disconnected is rejected.
- Edge cases:
  - Async reset during WaitHost leaves all outputs 0.
  - `link_resume_i` coinciding with the final timeout tick yields `wake_done_o` only.
